// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of the 32-bit FIFO between N_REQ producers.
//   Round-robin arbitration with burst grants, valid/ready toward producers,
//   zero-latency pass-through of the granted word onto the FIFO write side.
//
//   Each grant costs one arbitration cycle in IDLE. The grant is released on
//   req_last, after BURST_MAX words, or after TIMEOUT consecutive cycles with
//   the granted producer's valid low. FULL stalls never release the grant.
//
// Ports
//   Clk        : clock, all logic on the rising edge
//   Rst        : synchronous, active-high reset
//   req_valid  : per-producer word valid
//   req_data   : per-producer word, producer i at [i*DATA_W +: DATA_W]
//   req_last   : per-producer end-of-burst marker
//   req_ready  : per-producer accept, one-hot or zero
//   fifo_full  : FIFO FULL flag
//   fifo_en    : FIFO EN, registered, high from the first edge after reset
//   fifo_wr    : FIFO WR, high on a producer handshake
//   fifo_din   : FIFO dataIn, granted word on a handshake, else zero
//   grant_id   : current / last granted producer
//   busy       : high while a grant is held
//
// Optional feature
//   `define FIFO_ARB_PRIO_EN : producer 0 wins every arbitration it takes part
//   in, and releasing a producer-0 grant leaves the round-robin pointer alone.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_en,
  output logic                       fifo_wr,
  output logic [DATA_W-1:0]          fifo_din,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [7:0]    IDLE_LAST  = 8'(TIMEOUT - 1);
  localparam logic [GW-1:0] ID_LAST    = GW'(N_REQ - 1);

  logic [0:0]       state;
  logic [GW-1:0]    rr_ptr;
  logic [BW-1:0]    burst_cnt;
  logic [7:0]       idle_cnt;

  logic [N_REQ-1:0] hi_valid;
  logic [GW-1:0]    pick;
  logic             granted_live;
  logic             handshake;
  logic             release_now;
  logic [GW-1:0]    rr_next;

  // Round-robin pick: lowest requester at or above rr_ptr, otherwise wrap to
  // the lowest requester overall.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hi_valid = '0;
    pick     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_valid[i] = req_valid[i] && (GW'(i) >= rr_ptr);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) pick = GW'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hi_valid[i]) pick = GW'(i);
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid[0]) pick = '0;
`endif
  end

  // Rst gates the producer side in the very cycle it is sampled, so a word
  // offered then is not accepted and the producer re-presents it later.
  assign granted_live = (state == S_GRANT) && !Rst;
  assign handshake    = granted_live && req_valid[grant_id] && !fifo_full;
  assign busy         = (state == S_GRANT);
  assign rr_next      = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;

  // A FULL stall (valid high, FIFO full) matches neither term and holds.
  assign release_now = (state == S_GRANT) &&
                       ((handshake && (req_last[grant_id] || burst_cnt == BURST_LAST)) ||
                        (!req_valid[grant_id] && idle_cnt == IDLE_LAST));

  always_comb begin
    req_ready = '0;
    if (granted_live) req_ready[grant_id] = !fifo_full;
    fifo_wr  = handshake;
    fifo_din = handshake ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      fifo_en   <= 1'b0;
    end else begin
      fifo_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            grant_id  <= pick;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (handshake) begin
            burst_cnt <= burst_cnt + 1'b1;
            idle_cnt  <= '0;
          end else if (!req_valid[grant_id]) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (release_now) begin
            state <= S_IDLE;
`ifdef FIFO_ARB_PRIO_EN
            if (grant_id != '0) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's 32-bit FIFO (fifon) between N_REQ producers.
- Round-robin arbitration with burst grants. Valid/ready handshake toward producers. Drives the FIFO's EN/WR/dataIn and honours its FULL flag.
- Sits between producer blocks and the FIFO write side. The FIFO read side is untouched.

Parameters:
- DATA_W, 32, FIFO/producer data width.
- N_REQ, 4, number of producers (2..8).
- BURST_MAX, 4, maximum words accepted per grant (1..16).
- TIMEOUT, 8, consecutive cycles of idle valid on the granted producer before the grant is released (1..255).

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-producer word valid.
- req_data  in  N_REQ*DATA_W  per-producer word; producer i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  marks the final word of the producer's burst.
- req_ready  out  N_REQ  per-producer accept, one-hot or zero.
- fifo_full  in  1  FIFO FULL.
- fifo_en  out  1  to FIFO EN.
- fifo_wr  out  1  to FIFO WR.
- fifo_din  out  DATA_W  to FIFO dataIn.
- grant_id  out  $clog2(N_REQ)  currently/last granted producer.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (Rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, idle_cnt=0.
  - busy=0, req_ready=0, fifo_wr=0, fifo_din=0, fifo_en=0.
- fifo_en is registered: 0 during reset, 1 from the first edge after Rst deasserts.
- FSM states:
  - IDLE:
    - If any req_valid is set, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
    - Register the winner into grant_id, clear burst_cnt and idle_cnt, go to GRANT.
    - No writes occur in IDLE. There is a one-cycle arbitration bubble per grant.
  - GRANT:
    - req_ready[grant_id] = !fifo_full. All other req_ready bits are 0. This is combinational.
    - Handshake = req_valid[grant_id] & req_ready[grant_id].
    - fifo_wr = handshake (combinational). fifo_din = req_data[grant_id slice] when handshake, else 0.
    - Zero-cycle latency from handshake to FIFO write.
    - On handshake, burst_cnt increments. Release when req_last[grant_id]=1 or burst_cnt+1 == BURST_MAX.
    - If req_valid[grant_id]=0, idle_cnt increments; any handshake clears it. Release when idle_cnt+1 == TIMEOUT.
    - FULL stalls (valid=1, full=1) do not count toward TIMEOUT and never release the grant.
    - Release: go to IDLE, rr_ptr = grant_id+1 (wraps to 0 after N_REQ-1).
- Boundary cases:
  - fifo_full=1 at the cycle a handshake would occur: no write, no ready, counters unchanged.
  - fifo_full falling: the write happens in the same cycle.
  - Non-granted producers are never acknowledged, even if the FIFO has room.
  - req_last together with BURST_MAX limit in the same cycle: single release, no double update.
  - Rst mid-burst: immediate return to reset values. The partially delivered burst is not resumed. The producer sees req_ready drop the same cycle Rst is sampled and must re-present data.
  - A granted producer that deasserts valid and then reasserts it before TIMEOUT keeps its grant.
- grant_id holds its last value in IDLE. busy = (state==GRANT).

Optional Feature:
- Macro FIFO_ARB_PRIO_EN.
- Defined: producer 0 is high priority. In IDLE, if req_valid[0]=1 it wins regardless of rr_ptr, and rr_ptr is not updated on release of a producer-0 grant. Other producers keep round-robin among themselves.
- Undefined: pure round-robin as above. The priority logic is absent from the netlist.

Test Plan:
- Reset/idle:
  - Rst=1 for 5 cycles, then 0, all req_valid=0.
  - Expected: fifo_en=0 during reset, 1 one cycle after release. fifo_wr=0, busy=0, grant_id=0 throughout.
- Single burst:
  - Producer 2 presents 0x0..0x3 with req_last on 0x3, fifo_full=0.
  - Expected: grant_id=2 after 1 bubble cycle. Four consecutive fifo_wr pulses with fifo_din=0x0,0x1,0x2,0x3. Return to IDLE. rr_ptr=3.
- Round-robin fairness:
  - Producers 0,1,3 hold valid continuously with BURST_MAX=4 and no req_last.
  - Expected: grant order 0,1,3,0. Exactly 4 writes per grant, 1 bubble cycle between grants.
- FULL backpressure:
  - Producer 1 mid-burst, fifo_full=1 for 6 cycles.
  - Expected: req_ready[1]=0, fifo_wr=0, no timeout release. The write resumes in the cycle fifo_full falls, with fifo_din unchanged.
- Timeout and mid-burst reset:
  - Producer 3 sends one word then drops valid. TIMEOUT=8.
  - Expected: release after 8 idle cycles; a subsequent request from producer 0 is granted next.
  - Repeat with Rst asserted mid-burst. Expected: all outputs return to reset values on the next edge.
- FIFO_ARB_PRIO_EN:
  - Producers 0 and 2 both valid, rr_ptr=1.
  - Expected: producer 0 wins first. Without the macro, producer 2 wins first.
